// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the programmable synchronous FIFO.
package sync_fifo_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // True when n is a power of two and at least 2
    function automatic bit fifo_depth_ok(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_prog_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word at the write address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable registered/FWFT read, occupancy count,
// programmable almost-full/almost-empty flags, flush and error pulses.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = $clog2(DEPTH),
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wt_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_prog: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_prog: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_prog: AE_THRESH must be below DEPTH");
    end

    localparam logic [PTR_WIDTH:0] ONE    = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH + 1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_LVL = (PTR_WIDTH + 1)'(AE_THRESH);

    logic [PTR_WIDTH:0]    wt_pt;
    logic [PTR_WIDTH:0]    rd_pt;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come from registered pointers/count only, never from this cycle's requests
    assign full         = (wt_pt[PTR_WIDTH] != rd_pt[PTR_WIDTH]) &&
                          (wt_pt[PTR_WIDTH-1:0] == rd_pt[PTR_WIDTH-1:0]);
    assign empty        = (wt_pt == rd_pt);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // Flush overrides both requests so neither moves state nor raises an error
    assign wr_acc = wt_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    fifo_ram_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wt_pt[PTR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (rd_pt[PTR_WIDTH-1:0]),
        .rdata (ram_q)
    );

    // Pointer and occupancy bookkeeping; count moves only when exactly one side is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_pt <= '0;
            rd_pt <= '0;
            count <= '0;
        end else if (flush) begin
            wt_pt <= '0;
            rd_pt <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wt_pt <= wt_pt + ONE;
            if (rd_acc) rd_pt <= rd_pt + ONE;
            if (wr_acc && !rd_acc)      count <= count + ONE;
            else if (rd_acc && !wr_acc) count <= count - ONE;
        end
    end

    // One-cycle pulses for requests rejected because of full/empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= !flush && wt_en && full;
            underflow <= !flush && rd_en && empty;
        end
    end

    // Registered read data for the standard mode; holds between accepted reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
        end else if (flush) begin
            rd_data_p1 <= '0;
        end else if (rd_acc) begin
            rd_data_p1 <= ram_q;
        end
    end

    assign rdata = (FWFT == FIFO_MODE_FWFT) ? ram_q : rd_data_p1;

    // The occupancy counter must always track the pointer difference
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count == wt_pt - rd_pt)
                else $error("sync_fifo_prog: count diverged from pointer difference");
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench: one standard-read and one FWFT instance on a shared clock.
module tb_sync_fifo_prog;

    logic       clk;
    logic       rst_n;

    logic       s_flush, s_wt_en, s_rd_en;
    logic [7:0] s_wdata, s_rdata;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic [4:0] s_count;

    logic       f_flush, f_wt_en, f_rd_en;
    logic [7:0] f_wdata, f_rdata;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [4:0] f_count;

    int n_checks;
    int n_pass;

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .wt_en(s_wt_en), .wdata(s_wdata),
        .rd_en(s_rd_en), .rdata(s_rdata), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .wt_en(f_wt_en), .wdata(f_wdata),
        .rd_en(f_rd_en), .rdata(f_rdata), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ov), .underflow(f_un)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_flush = 0; s_wt_en = 0; s_rd_en = 0; s_wdata = '0;
        f_flush = 0; f_wt_en = 0; f_rd_en = 0; f_wdata = '0;
        tick();
        tick();
        n_checks++;
        if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin
            $display("FAIL reset_flags got=%b exp=1100", {s_empty, s_ae, s_full, s_af});
        end else n_pass++;
        n_checks++;
        if ({s_count, s_ov, s_un, s_rdata} !== 15'd0) begin
            $display("FAIL reset_regs count=%0d ov=%b un=%b rdata=%h exp all zero",
                     s_count, s_ov, s_un, s_rdata);
        end else n_pass++;
        n_checks++;
        if ({f_empty, f_full, f_count} !== 7'b1000000) begin
            $display("FAIL reset_fwft empty=%b full=%b count=%0d exp 1,0,0", f_empty, f_full, f_count);
        end else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            s_wt_en = 1; s_wdata = 8'(i);
            tick();
            n_checks++;
            if (s_count !== 5'(i + 1) || s_af !== (i + 1 >= 14) || s_full !== (i + 1 == 16)) begin
                $display("FAIL fill_%0d count=%0d af=%b full=%b exp count=%0d af=%b full=%b",
                         i, s_count, s_af, s_full, i + 1, (i + 1 >= 14), (i + 1 == 16));
            end else n_pass++;
        end
        s_wdata = 8'hEE;
        tick();
        n_checks++;
        if ({s_ov, s_full, s_count} !== {1'b1, 1'b1, 5'd16}) begin
            $display("FAIL overflow_write ov=%b full=%b count=%0d exp 1,1,16", s_ov, s_full, s_count);
        end else n_pass++;
        s_wt_en = 0;
        tick();
        n_checks++;
        if (s_ov !== 1'b0) begin
            $display("FAIL overflow_pulse_len ov=%b exp 0", s_ov);
        end else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1;
            tick();
            n_checks++;
            if (s_rdata !== 8'(i) || s_count !== 5'(15 - i) || s_ae !== (15 - i <= 2)) begin
                $display("FAIL drain_%0d rdata=%h count=%0d ae=%b exp rdata=%h count=%0d ae=%b",
                         i, s_rdata, s_count, s_ae, 8'(i), 15 - i, (15 - i <= 2));
            end else n_pass++;
        end
        tick();
        n_checks++;
        if ({s_un, s_empty, s_rdata} !== {1'b1, 1'b1, 8'h0F}) begin
            $display("FAIL underflow_read un=%b empty=%b rdata=%h exp 1,1,0f", s_un, s_empty, s_rdata);
        end else n_pass++;
        s_rd_en = 0;
        tick();
        n_checks++;
        if (s_un !== 1'b0) begin
            $display("FAIL underflow_pulse_len un=%b exp 0", s_un);
        end else n_pass++;
    endtask

    task automatic test_fwft();
        f_wt_en = 1; f_wdata = 8'hA5;
        tick();
        f_wt_en = 0;
        n_checks++;
        if ({f_empty, f_rdata, f_count} !== {1'b0, 8'hA5, 5'd1}) begin
            $display("FAIL fwft_visible empty=%b rdata=%h count=%0d exp 0,a5,1", f_empty, f_rdata, f_count);
        end else n_pass++;
        tick();
        n_checks++;
        if (f_rdata !== 8'hA5) begin
            $display("FAIL fwft_hold rdata=%h exp a5", f_rdata);
        end else n_pass++;
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        n_checks++;
        if ({f_empty, f_count, f_un} !== {1'b1, 5'd0, 1'b0}) begin
            $display("FAIL fwft_pop empty=%b count=%0d un=%b exp 1,0,0", f_empty, f_count, f_un);
        end else n_pass++;
        f_wt_en = 1; f_wdata = 8'h11;
        tick();
        f_wdata = 8'h22;
        tick();
        f_wt_en = 0;
        n_checks++;
        if ({f_rdata, f_count} !== {8'h11, 5'd2}) begin
            $display("FAIL fwft_head rdata=%h count=%0d exp 11,2", f_rdata, f_count);
        end else n_pass++;
        f_rd_en = 1;
        tick();
        n_checks++;
        if ({f_rdata, f_count} !== {8'h22, 5'd1}) begin
            $display("FAIL fwft_next rdata=%h count=%0d exp 22,1", f_rdata, f_count);
        end else n_pass++;
        tick();
        f_rd_en = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            s_wt_en = 1; s_wdata = 8'(i);
            tick();
        end
        n_checks++;
        if (s_count !== 5'd8) begin
            $display("FAIL b2b_prefill count=%0d exp 8", s_count);
        end else n_pass++;
        s_rd_en = 1;
        for (int k = 0; k < 40; k++) begin
            s_wdata = 8'(8 + k);
            tick();
            n_checks++;
            if ({s_rdata, s_count, s_ov, s_un} !== {8'(k), 5'd8, 2'b00}) begin
                $display("FAIL b2b_%0d rdata=%h count=%0d ov=%b un=%b exp rdata=%h count=8 ov=0 un=0",
                         k, s_rdata, s_count, s_ov, s_un, 8'(k));
            end else n_pass++;
        end
        s_wt_en = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (s_rdata !== 8'(40 + k)) begin
                $display("FAIL b2b_drain_%0d rdata=%h exp %h", k, s_rdata, 8'(40 + k));
            end else n_pass++;
        end
        s_rd_en = 0;
        n_checks++;
        if (s_empty !== 1'b1) begin
            $display("FAIL b2b_empty empty=%b exp 1", s_empty);
        end else n_pass++;
    endtask

    task automatic test_full_empty_both();
        for (int i = 0; i < 16; i++) begin
            s_wt_en = 1; s_wdata = 8'(8'h80 + i);
            tick();
        end
        s_rd_en = 1; s_wdata = 8'hFF;
        tick();
        s_wt_en = 0; s_rd_en = 0;
        n_checks++;
        if ({s_ov, s_count, s_rdata} !== {1'b1, 5'd15, 8'h80}) begin
            $display("FAIL full_both ov=%b count=%0d rdata=%h exp 1,15,80", s_ov, s_count, s_rdata);
        end else n_pass++;
        s_rd_en = 1;
        for (int i = 0; i < 15; i++) tick();
        s_rd_en = 0;
        n_checks++;
        if ({s_rdata, s_empty} !== {8'h8F, 1'b1}) begin
            $display("FAIL full_both_tail rdata=%h empty=%b exp 8f,1", s_rdata, s_empty);
        end else n_pass++;
        s_wt_en = 1; s_rd_en = 1; s_wdata = 8'h3C;
        tick();
        s_wt_en = 0; s_rd_en = 0;
        n_checks++;
        if ({s_un, s_count, s_rdata} !== {1'b1, 5'd1, 8'h8F}) begin
            $display("FAIL empty_both un=%b count=%0d rdata=%h exp 1,1,8f", s_un, s_count, s_rdata);
        end else n_pass++;
        s_rd_en = 1;
        tick();
        s_rd_en = 0;
        n_checks++;
        if ({s_rdata, s_empty} !== {8'h3C, 1'b1}) begin
            $display("FAIL empty_both_pop rdata=%h empty=%b exp 3c,1", s_rdata, s_empty);
        end else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) begin
            s_wt_en = 1; s_wdata = 8'(8'h20 + i);
            tick();
        end
        n_checks++;
        if (s_count !== 5'd9) begin
            $display("FAIL flush_prefill count=%0d exp 9", s_count);
        end else n_pass++;
        s_flush = 1; s_rd_en = 1; s_wdata = 8'h55;
        tick();
        s_flush = 0; s_wt_en = 0; s_rd_en = 0;
        n_checks++;
        if ({s_count, s_empty, s_ov, s_un, s_rdata} !== {5'd0, 1'b1, 2'b00, 8'h00}) begin
            $display("FAIL flush count=%0d empty=%b ov=%b un=%b rdata=%h exp 0,1,0,0,00",
                     s_count, s_empty, s_ov, s_un, s_rdata);
        end else n_pass++;
        s_wt_en = 1; s_wdata = 8'h77;
        tick();
        s_wt_en = 0; s_rd_en = 1;
        tick();
        s_rd_en = 0;
        n_checks++;
        if ({s_rdata, s_empty} !== {8'h77, 1'b1}) begin
            $display("FAIL post_flush rdata=%h empty=%b exp 77,1", s_rdata, s_empty);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        s_wt_en = 1; f_wt_en = 1;
        for (int i = 0; i < 5; i++) begin
            s_wdata = 8'(8'h60 + i); f_wdata = 8'(8'h60 + i);
            tick();
        end
        n_checks++;
        if ({s_count, f_count} !== {5'd5, 5'd5}) begin
            $display("FAIL burst_count s=%0d f=%0d exp 5,5", s_count, f_count);
        end else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_count, s_empty, s_full, s_rdata, s_ov, s_un} !== {5'd0, 1'b1, 1'b0, 8'h00, 2'b00}) begin
            $display("FAIL async_reset count=%0d empty=%b full=%b rdata=%h ov=%b un=%b exp 0,1,0,00,0,0",
                     s_count, s_empty, s_full, s_rdata, s_ov, s_un);
        end else n_pass++;
        n_checks++;
        if ({f_count, f_empty, f_ae} !== {5'd0, 1'b1, 1'b1}) begin
            $display("FAIL async_reset_fwft count=%0d empty=%b ae=%b exp 0,1,1", f_count, f_empty, f_ae);
        end else n_pass++;
        s_wt_en = 0; f_wt_en = 0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_back_to_back();
        test_full_empty_both();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
